// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared register map, bit positions and FSM state type for the ADC sequencer
//
// Holds the byte offsets of every APB register, the CTRL/STATUS bit
// positions, the SETTLE reset value and the sequencer state enum.
package adc_seq_pkg;

  // Register byte offsets
  localparam int OFF_CTRL   = 'h000;
  localparam int OFF_MASK   = 'h004;
  localparam int OFF_TRIG   = 'h008;
  localparam int OFF_STATUS = 'h00C;
  localparam int OFF_SETTLE = 'h010;
  localparam int OFF_RESULT = 'h100;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_TOUT   = 3;
  localparam int STAT_CH_LSB = 8;

  // RESULT valid flag position
  localparam int RES_VALID = 31;

  localparam logic [15:0] SETTLE_RST = 16'd16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_NEXT    = 2'd3
  } seq_state_e;

  // Byte offset to 32-bit word index, matching the PADDR[ADDR_WIDTH-1:2] decode
  function automatic int word_idx(input int off);
    return off >> 2;
  endfunction

endpackage

// File: rtl/adc_seq_apb_if.sv
// rtl/adc_seq_apb_if.sv - APB bus bundle for the ADC sequencer
//
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA (master -> slave),
//          PRDATA, PREADY, PSLVERR (slave -> master).
// Modports: master (bus side), slave (peripheral side).
interface adc_seq_apb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/adc_seq_chan_pick.sv
// rtl/adc_seq_chan_pick.sv - combinational priority encoder choosing the next scan channel
//
// Ports:
//   i_mask  [NUM_CH] enabled channels
//   i_start [CH_W]   current channel; search begins above it
//   i_first          ignore i_start and return the lowest set bit
//   o_ch    [CH_W]   selected channel (0 when none found)
//   o_found          a qualifying set bit exists
module adc_seq_chan_pick #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_start,
  input  logic              i_first,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_found
);

  // Walk downward so the lowest qualifying index is the one left standing
  always_comb begin
    o_ch    = '0;
    o_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_start)))) begin
        o_ch    = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_seq_apb.sv
// rtl/adc_seq_apb.sv - multi-channel ADC scan sequencer with APB register access
//
// Ports:
//   PCLK, PRESETn    clock, asynchronous active-low reset
//   apb              APB slave (adc_seq_apb_if.slave), zero wait states
//   amux_sel [CH_W]  analog mux channel select
//   adc_start        one-cycle conversion start pulse
//   adc_done         one-cycle conversion complete pulse
//   adc_data         conversion result, valid with adc_done
//   irq              level interrupt: IRQ_EN & (DONE | OVR | TOUT)
module adc_seq_apb
  import adc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 8,
  parameter int RES_BITS    = 12,
  parameter int TOUT_CYCLES = 1024,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  adc_seq_apb_if.slave        apb,
  output logic [CH_W-1:0]     amux_sel,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [RES_BITS-1:0] adc_data,
  output logic                irq
);

  localparam int WIDX = ADDR_WIDTH - 2;
  localparam int TW   = $clog2(TOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT_CYCLES - 1);

  // Software-visible state
  logic                r_en, r_cont, r_irq_en;
  logic [NUM_CH-1:0]   r_mask;
  logic [15:0]         r_settle;
  logic                r_done, r_ovr, r_tout;
  logic [RES_BITS-1:0] r_res [NUM_CH];
  logic [NUM_CH-1:0]   r_valid;

  // Sequencer state
  seq_state_e          r_state;
  logic [CH_W-1:0]     r_ch;
  logic [15:0]         r_settle_cnt;
  logic [TW-1:0]       r_tout_cnt;
  logic                r_wrap;

  // Address decode
  logic [WIDX-1:0] w_word;
  logic            w_sel_ctrl, w_sel_mask, w_sel_trig, w_sel_status, w_sel_settle, w_sel_res;
  logic            w_addr_ok;
  logic [CH_W-1:0] w_res_idx;
  logic            w_wr, w_rd_res, w_rd_same, w_wr_status;

  logic            w_trig, w_cap, w_tout_hit;
  logic            w_set_done, w_set_ovr, w_set_tout;
  logic            w_pick_first, w_pick_found;
  logic [CH_W-1:0] w_pick_ch;
  logic            w_unused;

  assign w_word       = apb.PADDR[ADDR_WIDTH-1:2];
  assign w_sel_ctrl   = (w_word == WIDX'(word_idx(OFF_CTRL)));
  assign w_sel_mask   = (w_word == WIDX'(word_idx(OFF_MASK)));
  assign w_sel_trig   = (w_word == WIDX'(word_idx(OFF_TRIG)));
  assign w_sel_status = (w_word == WIDX'(word_idx(OFF_STATUS)));
  assign w_sel_settle = (w_word == WIDX'(word_idx(OFF_SETTLE)));
  assign w_sel_res    = (w_word >= WIDX'(word_idx(OFF_RESULT))) &&
                        (w_word <  WIDX'(word_idx(OFF_RESULT) + NUM_CH));
  assign w_res_idx    = CH_W'(w_word - WIDX'(word_idx(OFF_RESULT)));
  assign w_addr_ok    = w_sel_ctrl | w_sel_mask | w_sel_trig | w_sel_status |
                        w_sel_settle | w_sel_res;

  assign w_wr        = apb.PSEL & apb.PENABLE & apb.PWRITE & w_addr_ok;
  assign w_wr_status = w_wr & w_sel_status;
  assign w_rd_res    = apb.PSEL & apb.PENABLE & ~apb.PWRITE & w_sel_res;
  assign w_rd_same   = w_rd_res && (w_res_idx == r_ch);

  assign w_unused = ^{apb.PWDATA[DATA_WIDTH-1:16], apb.PADDR[1:0]};

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~w_addr_ok;

  // Read mux; unmapped addresses fall through to zero
  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      if (w_sel_ctrl) begin
        apb.PRDATA[CTRL_EN]     = r_en;
        apb.PRDATA[CTRL_CONT]   = r_cont;
        apb.PRDATA[CTRL_IRQ_EN] = r_irq_en;
      end else if (w_sel_mask) begin
        apb.PRDATA[NUM_CH-1:0] = r_mask;
      end else if (w_sel_status) begin
        apb.PRDATA[STAT_BUSY]          = (r_state != S_IDLE);
        apb.PRDATA[STAT_DONE]          = r_done;
        apb.PRDATA[STAT_OVR]           = r_ovr;
        apb.PRDATA[STAT_TOUT]          = r_tout;
        apb.PRDATA[STAT_CH_LSB +: CH_W] = r_ch;
      end else if (w_sel_settle) begin
        apb.PRDATA[15:0] = r_settle;
      end else if (w_sel_res) begin
        apb.PRDATA[RES_BITS-1:0] = r_res[w_res_idx];
        apb.PRDATA[RES_VALID]    = r_valid[w_res_idx];
      end
    end
  end

  // In IDLE and on the CONT wrap cycle the encoder looks for the lowest bit;
  // otherwise it looks for the next bit above the current channel.
  assign w_pick_first = (r_state == S_IDLE) || r_wrap;

  adc_seq_chan_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .i_mask  (r_mask),
    .i_start (r_ch),
    .i_first (w_pick_first),
    .o_ch    (w_pick_ch),
    .o_found (w_pick_found)
  );

  assign w_trig = w_wr & w_sel_trig & apb.PWDATA[0] & (r_state == S_IDLE) &
                  r_en & w_pick_found;

  // Everything below is gated by EN so a cleared EN freezes results for the
  // one cycle before the FSM falls back to IDLE.
  assign adc_start  = (r_state == S_SETTLE) & r_en & (r_settle_cnt == 16'd0);
  assign w_cap      = (r_state == S_CONVERT) & r_en & adc_done;
  assign w_tout_hit = (r_state == S_CONVERT) & r_en & ~adc_done & (r_tout_cnt == TOUT_LAST);
  assign w_set_done = (r_state == S_NEXT) & r_en & ~w_pick_found & ~r_wrap;
  // A same-cycle read of the captured channel consumes the old value, so no overrun
  assign w_set_ovr  = w_cap & r_valid[r_ch] & ~w_rd_same;
  assign w_set_tout = w_tout_hit;

  assign amux_sel = r_ch;
  assign irq      = r_irq_en & (r_done | r_ovr | r_tout);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_settle_cnt <= '0;
      r_tout_cnt   <= '0;
      r_wrap       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state      <= S_SETTLE;
            r_ch         <= w_pick_ch;
            r_settle_cnt <= r_settle;
          end
        end
        S_SETTLE: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else if (r_settle_cnt == 16'd0) begin
            r_state    <= S_CONVERT;
            r_tout_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt - 16'd1;
          end
        end
        S_CONVERT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else if (adc_done || w_tout_hit) begin
            r_state <= S_NEXT;
          end else begin
            r_tout_cnt <= r_tout_cnt + TW'(1);
          end
        end
        S_NEXT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
            r_wrap  <= 1'b0;
          end else if (w_pick_found) begin
            r_state      <= S_SETTLE;
            r_ch         <= w_pick_ch;
            r_settle_cnt <= r_settle;
            r_wrap       <= 1'b0;
          end else if (r_cont && !r_wrap) begin
            // End of pass in continuous mode: spend one cycle re-searching
            // from the lowest bit with the same encoder.
            r_wrap <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_wrap  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en     <= 1'b0;
      r_cont   <= 1'b0;
      r_irq_en <= 1'b0;
      r_mask   <= '0;
      r_settle <= SETTLE_RST;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_tout   <= 1'b0;
      r_valid  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_res[n] <= '0;
      end
    end else begin
      if (w_wr && w_sel_ctrl) begin
        r_en     <= apb.PWDATA[CTRL_EN];
        r_cont   <= apb.PWDATA[CTRL_CONT];
        r_irq_en <= apb.PWDATA[CTRL_IRQ_EN];
      end
      if (w_wr && w_sel_mask) begin
        r_mask <= apb.PWDATA[NUM_CH-1:0];
      end
      if (w_wr && w_sel_settle) begin
        r_settle <= apb.PWDATA[15:0];
      end

      // Hardware set beats a simultaneous write-1-to-clear
      r_done <= w_set_done | (r_done & ~(w_wr_status & apb.PWDATA[STAT_DONE]));
      r_ovr  <= w_set_ovr  | (r_ovr  & ~(w_wr_status & apb.PWDATA[STAT_OVR]));
      r_tout <= w_set_tout | (r_tout & ~(w_wr_status & apb.PWDATA[STAT_TOUT]));

      for (int n = 0; n < NUM_CH; n++) begin
        if (w_cap && (r_ch == CH_W'(n))) begin
          r_res[n]   <= adc_data;
          r_valid[n] <= 1'b1;
        end else if (w_rd_res && (w_res_idx == CH_W'(n))) begin
          r_valid[n] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_seq_apb.sv
// tb/tb_adc_seq_apb.sv - scoreboard bench for adc_seq_apb
module tb_adc_seq_apb;

  logic        pclk;
  logic        presetn;
  logic [2:0]  amux_sel;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        irq;

  adc_seq_apb_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) apb_if ();

  adc_seq_apb #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(8), .RES_BITS(12), .TOUT_CYCLES(1024)
  ) dut (
    .PCLK      (pclk),
    .PRESETn   (presetn),
    .apb       (apb_if.slave),
    .amux_sel  (amux_sel),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .irq       (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Read scoreboard
  string       rd_name_q[$];
  logic [31:0] rd_data_q[$];
  logic        rd_err_q[$];
  // Expected amux_sel at each adc_start
  int          start_q[$];
  bit          strict = 1'b1;

  // ADC model
  logic [11:0] tbl [8];
  bit          model_en = 1'b1;
  int          model_lat = 5;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read-response monitor
  always @(negedge pclk) begin
    if (apb_if.PSEL && apb_if.PENABLE && !apb_if.PWRITE) begin
      if (rd_name_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", apb_if.PRDATA);
      end else begin
        string nm;
        logic [31:0] d;
        logic e;
        nm = rd_name_q.pop_front();
        d  = rd_data_q.pop_front();
        e  = rd_err_q.pop_front();
        chk({nm, "_data"}, apb_if.PRDATA, d);
        chk({nm, "_err"}, {31'd0, apb_if.PSLVERR}, {31'd0, e});
      end
    end
  end

  // Conversion-start monitor
  always @(negedge pclk) begin
    if (presetn && adc_start === 1'b1) begin
      if (start_q.size() > 0) begin
        int e;
        e = start_q.pop_front();
        chk("start_ch", {29'd0, amux_sel}, e[31:0]);
      end else if (strict) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_start: got ch %0d expected no start", amux_sel);
      end
    end
  end

  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge pclk);
      if (adc_start === 1'b1 && model_en) begin
        logic [2:0] ch;
        ch = amux_sel;
        repeat (model_lat) @(posedge pclk);
        #1;
        adc_done = 1'b1;
        adc_data = tbl[ch];
        @(posedge pclk);
        #1;
        adc_done = 1'b0;
      end
    end
  end

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge pclk); #1;
    apb_if.PSEL = 1'b1; apb_if.PWRITE = 1'b1; apb_if.PENABLE = 1'b0;
    apb_if.PADDR = addr; apb_if.PWDATA = data;
    @(posedge pclk); #1;
    apb_if.PENABLE = 1'b1;
    @(posedge pclk); #1;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [11:0] addr,
                          input logic [31:0] exp, input logic exp_err);
    @(posedge pclk); #1;
    rd_name_q.push_back(name); rd_data_q.push_back(exp); rd_err_q.push_back(exp_err);
    apb_if.PSEL = 1'b1; apb_if.PWRITE = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PADDR = addr;
    @(posedge pclk); #1;
    apb_if.PENABLE = 1'b1;
    @(posedge pclk); #1;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
  endtask

  // Counts falling edges from the TRIG commit until adc_start is seen
  task automatic start_latency(input string name, input int exp);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 64) begin
      @(negedge pclk);
      k++;
      if (adc_start === 1'b1) seen = 1'b1;
    end
    if (!seen) k = -1;
    chk(name, k[31:0], exp[31:0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 12'hABC; tbl[1] = 12'h001; tbl[2] = 12'h123; tbl[3] = 12'h003;
    tbl[4] = 12'h004; tbl[5] = 12'h005; tbl[6] = 12'h006; tbl[7] = 12'h5A5;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = '0; apb_if.PWDATA = '0;
    presetn = 1'b0;

    // Reset values
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_prdata", apb_if.PRDATA, 32'h0);
    chk("rst_pslverr", {31'd0, apb_if.PSLVERR}, 32'h0);
    chk("rst_pready", {31'd0, apb_if.PREADY}, 32'h1);
    chk("rst_amux", {29'd0, amux_sel}, 32'h0);
    chk("rst_start", {31'd0, adc_start}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    presetn = 1'b1;
    apb_read("rst_ctrl",   12'h000, 32'h0, 1'b0);
    apb_read("rst_mask",   12'h004, 32'h0, 1'b0);
    apb_read("rst_settle", 12'h010, 32'h10, 1'b0);
    apb_read("rst_status", 12'h00C, 32'h0, 1'b0);
    apb_read("rst_res0",   12'h100, 32'h0, 1'b0);

    // One-shot scan of ch0 and ch2
    apb_write(12'h010, 32'd3);
    apb_write(12'h004, 32'h05);
    apb_write(12'h000, 32'h5);
    start_q.push_back(0);
    start_q.push_back(2);
    apb_write(12'h008, 32'h1);
    start_latency("t1_start_lat", 4);
    repeat (40) @(posedge pclk);
    apb_read("t1_status", 12'h00C, 32'h0000_0202, 1'b0);
    #1;
    chk("t1_irq", {31'd0, irq}, 32'h1);
    apb_read("t1_res0", 12'h100, 32'h8000_0ABC, 1'b0);
    apb_read("t1_res2", 12'h108, 32'h8000_0123, 1'b0);
    apb_read("t1_res1", 12'h104, 32'h0, 1'b0);
    apb_read("t1_res0_clr", 12'h100, 32'h0000_0ABC, 1'b0);
    apb_write(12'h00C, 32'h2);
    chk("t1_irq_clr", {31'd0, irq}, 32'h0);

    // Continuous scan of ch7, never read -> overrun
    strict = 1'b0;
    apb_write(12'h004, 32'h80);
    apb_write(12'h000, 32'h7);
    apb_write(12'h008, 32'h1);
    repeat (40) @(posedge pclk);
    apb_read("t2_status", 12'h00C, 32'h0000_0707, 1'b0);
    chk("t2_irq", {31'd0, irq}, 32'h1);
    apb_write(12'h000, 32'h4);
    repeat (2) @(posedge pclk);
    strict = 1'b1;
    apb_read("t2_res7", 12'h11C, 32'h8000_05A5, 1'b0);
    apb_write(12'h00C, 32'h4);
    apb_read("t2_status_ovr_clr", 12'h00C, 32'h0000_0702, 1'b0);
    chk("t2_irq_done_only", {31'd0, irq}, 32'h1);
    apb_write(12'h00C, 32'h2);
    chk("t2_irq_drop", {31'd0, irq}, 32'h0);
    apb_read("t2_status_clr", 12'h00C, 32'h0000_0700, 1'b0);

    // Timeouts on both channels, SETTLE=0
    model_en = 1'b0;
    apb_write(12'h010, 32'd0);
    apb_write(12'h004, 32'h05);
    apb_write(12'h000, 32'h5);
    start_q.push_back(0);
    start_q.push_back(2);
    apb_write(12'h008, 32'h1);
    start_latency("t3_start_lat", 1);
    repeat (1015) @(posedge pclk);
    apb_read("t3_before_tout", 12'h00C, 32'h0000_0001, 1'b0);
    repeat (5) @(posedge pclk);
    apb_read("t3_at_tout", 12'h00C, 32'h0000_0009, 1'b0);
    repeat (1100) @(posedge pclk);
    apb_read("t3_status", 12'h00C, 32'h0000_020A, 1'b0);
    apb_read("t3_res0", 12'h100, 32'h0000_0ABC, 1'b0);
    apb_read("t3_res2", 12'h108, 32'h0000_0123, 1'b0);
    chk("t3_irq", {31'd0, irq}, 32'h1);

    // EN cleared in CONVERT, late adc_done ignored
    apb_write(12'h00C, 32'hE);
    model_en = 1'b1;
    model_lat = 20;
    tbl[0] = 12'h777;
    apb_write(12'h010, 32'd2);
    apb_write(12'h004, 32'h01);
    apb_write(12'h000, 32'h1);
    start_q.push_back(0);
    apb_write(12'h008, 32'h1);
    start_latency("t4_start_lat", 3);
    apb_write(12'h000, 32'h0);
    repeat (40) @(posedge pclk);
    apb_read("t4_status", 12'h00C, 32'h0, 1'b0);
    apb_read("t4_res0", 12'h100, 32'h0000_0ABC, 1'b0);
    model_lat = 5;
    tbl[0] = 12'hABC;

    // Ignored triggers and bad address
    apb_write(12'h010, 32'd10);
    apb_write(12'h000, 32'h1);
    start_q.push_back(0);
    apb_write(12'h008, 32'h1);
    apb_write(12'h008, 32'h1);
    repeat (40) @(posedge pclk);
    apb_read("t5_status", 12'h00C, 32'h0000_0002, 1'b0);
    apb_read("t5_res0", 12'h100, 32'h8000_0ABC, 1'b0);
    apb_write(12'h004, 32'h0);
    apb_write(12'h008, 32'h1);
    repeat (20) @(posedge pclk);
    apb_read("t5_mask0_status", 12'h00C, 32'h0000_0002, 1'b0);
    apb_write(12'h000, 32'h0);
    apb_write(12'h004, 32'h1);
    apb_write(12'h008, 32'h1);
    repeat (20) @(posedge pclk);
    apb_read("t5_en0_status", 12'h00C, 32'h0000_0002, 1'b0);
    apb_read("t5_bad_addr", 12'h014, 32'h0, 1'b1);
    apb_read("t5_trig_rd", 12'h008, 32'h0, 1'b0);
    apb_read("t5_mask_rd", 12'h004, 32'h1, 1'b0);

    // Asynchronous reset mid-SETTLE
    apb_write(12'h010, 32'd50);
    apb_write(12'h004, 32'h04);
    apb_write(12'h000, 32'h5);
    apb_write(12'h008, 32'h1);
    repeat (3) @(posedge pclk);
    apb_read("t6_pre_status", 12'h00C, 32'h0000_0203, 1'b0);
    chk("t6_pre_amux", {29'd0, amux_sel}, 32'h2);
    chk("t6_pre_irq", {31'd0, irq}, 32'h1);
    #2;
    presetn = 1'b0;
    #1;
    chk("t6_amux", {29'd0, amux_sel}, 32'h0);
    chk("t6_irq", {31'd0, irq}, 32'h0);
    chk("t6_start", {31'd0, adc_start}, 32'h0);
    chk("t6_prdata", apb_if.PRDATA, 32'h0);
    chk("t6_pslverr", {31'd0, apb_if.PSLVERR}, 32'h0);
    chk("t6_pready", {31'd0, apb_if.PREADY}, 32'h1);
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    apb_read("t6_ctrl",   12'h000, 32'h0, 1'b0);
    apb_read("t6_mask",   12'h004, 32'h0, 1'b0);
    apb_read("t6_settle", 12'h010, 32'h10, 1'b0);
    apb_read("t6_status", 12'h00C, 32'h0, 1'b0);
    apb_read("t6_res0",   12'h100, 32'h0, 1'b0);
    apb_read("t6_res2",   12'h108, 32'h0, 1'b0);

    repeat (5) @(posedge pclk);
    chk("start_q_empty", start_q.size(), 32'd0);
    chk("rd_q_empty", rd_name_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_seq_apb.md
# adc_seq_apb

Multi-channel ADC sequencer with an APB slave interface and parametrised channel count, resolution and settle time. Software picks a channel mask and triggers a scan, either one-shot or continuous. The block steps the analog mux through the enabled channels, waits a programmable settle time, and handshakes each conversion with the ADC macro. Each result lands in a per-channel register with valid, overrun and timeout flags, and a level interrupt is raised. It sits on the peripheral APB segment between the bus and the ADC/AMUX macros.

## Interface
- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width (must be 32)
- NUM_CH, 8, analog channels (2..16)
- RES_BITS, 12, ADC result width (≤16)
- TOUT_CYCLES, 1024, max cycles from adc_start to adc_done
- CH_W, $clog2(NUM_CH), channel index width (derived)

Ports (all synchronous to the clock):
- PCLK  in  1  clock
- PRESETn  in  1  reset; one clock, asynchronous, active-low
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  ADDR_WIDTH  byte address; decode on PADDR[ADDR_WIDTH-1:2]
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  tied 1, zero wait states
- PSLVERR  out  1  unmapped-address error
- amux_sel  out  CH_W  AMUX channel select
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  one-cycle conversion complete pulse
- adc_data  in  RES_BITS  result, valid when adc_done=1
- irq  out  1  level interrupt

## Operation
Register map, by byte offset:
- 0x000 CTRL (RW): bit0 EN, bit1 CONT, bit2 IRQ_EN.
- 0x004 MASK (RW): bits [NUM_CH-1:0].
- 0x008 TRIG (WO): write with bit0=1 starts a scan. Reads as 0.
- 0x00C STATUS:
  - bit0 BUSY (RO).
  - bit1 DONE, bit2 OVR, bit3 TOUT: sticky, write-1-to-clear.
  - bits[8+:CH_W] current channel (RO).
- 0x010 SETTLE (RW): bits[15:0], default 16.
- 0x100+4n RESULT[n], n<NUM_CH (RO): bits[RES_BITS-1:0] data, bit31 VALID. A read clears VALID.

Bus behaviour:
- Any other address gives PSLVERR=1 in the access phase. The write is dropped and the read returns 0.
- PRDATA is combinational. It is valid when PSEL&~PWRITE; otherwise it is 0.
- Writes commit on the edge where PSEL&PENABLE&PWRITE.

State machine:
- IDLE → SETTLE when TRIG is written with EN=1 and MASK≠0. On entry:
  - ch is loaded with the lowest set MASK bit.
  - The settle counter is loaded with SETTLE.
  - BUSY=1.
- SETTLE: counter decrements each cycle. In the cycle where it reads 0, assert adc_start and go to CONVERT with the timeout counter cleared.
- CONVERT, on adc_done:
  - Write RESULT[ch].
  - If VALID was already 1, set OVR.
  - Set VALID and go to NEXT.
- CONVERT, if the timeout counter reaches TOUT_CYCLES-1 first: set TOUT, leave RESULT[ch] unchanged, go to NEXT.
- NEXT:
  - If a higher set MASK bit exists, load ch with it, reload the settle counter, and go to SETTLE.
  - Otherwise set DONE. Then, if CONT, restart from the lowest set bit (SETTLE); else go to IDLE with BUSY=0.
- irq = IRQ_EN & (DONE|OVR|TOUT).

Boundary rules:
- TRIG while BUSY: ignored.
- TRIG with MASK=0 or EN=0: ignored.
- EN cleared mid-scan: go to IDLE on the next edge. No result is written, a late adc_done is ignored, and DONE is not set.
- MASK change mid-scan: takes effect at the next NEXT evaluation. If MASK=0 at NEXT, the scan ends as if no higher bit exists.
- SETTLE=0: adc_start in the cycle after entering SETTLE.
- RESULT read and capture of the same channel in the same cycle: the capture wins (VALID=1) and no OVR is set.
- Sticky-flag set and W1C in the same cycle: the set wins.
- Reset mid-scan: immediate IDLE and all registers cleared.

## Timing
- Reset values:
  - PRDATA=0, PSLVERR=0, PREADY=1.
  - amux_sel=0, adc_start=0, irq=0.
  - CTRL=0, MASK=0, SETTLE=16, STATUS=0, all RESULT=0.
- TRIG write at edge T:
  - BUSY=1 and amux_sel valid from T+1.
  - adc_start is high in cycle T+1+SETTLE.
- adc_done at edge D: RESULT and VALID are visible from D+1.
- The next channel's amux_sel is valid at D+2.
- A one-shot scan sets DONE at the edge after the last NEXT. BUSY clears on the same edge.

## Structure
- Package adc_seq_pkg holds:
  - register offsets and CTRL/STATUS bit positions;
  - the state enum {IDLE, SETTLE, CONVERT, NEXT};
  - the SETTLE reset constant.
- Sub-module adc_seq_chan_pick is a combinational priority encoder.
  - Inputs: mask, start index, first flag.
  - Outputs: next channel and found flag.
  - Instantiated once.

## Test plan
- MASK=0x05, SETTLE=3, one-shot; model returns 0xABC on ch0 and 0x123 on ch2, 5 cycles after start.
  - amux_sel sequence 0 then 2; adc_start 4 cycles after TRIG; RESULT0=0x8000_0ABC, RESULT2=0x8000_0123; DONE=1, BUSY=0, irq=1 with IRQ_EN=1.
- Set CONT and MASK=0x80, never read RESULT7 → OVR=1 after the second conversion. W1C 0x4 clears OVR and irq drops next cycle if DONE is also cleared.
- Model never pulses adc_done, TOUT_CYCLES=1024 → TOUT=1 after 1024 cycles in CONVERT, RESULT unchanged, scan proceeds to the next channel.
- Clear EN while in CONVERT, then a late adc_done → IDLE, BUSY=0, no RESULT write, DONE=0.
- TRIG during BUSY, TRIG with MASK=0, and a read of offset 0x014 → no new scan and PSLVERR=1 with PRDATA=0 for the bad address.
- Assert PRESETn low mid-SETTLE → all outputs and registers at reset values immediately, without waiting for a PCLK edge.
